sseg_count_ctrl: RTL and testbench

Controller that sequences a two-digit decimal counter and drives both Go Board seven-segment displays. An internal prescaler produces the count tick; an IDLE/RUN/PAUSE state machine gates it from start, stop and clear pulses. The BCD count is encoded to active-low segment patterns inside the block. It sits between the board's debounced button logic and the display pins and replaces any per-digit incrementer logic.

---
 rtl/sseg_count_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sseg_count_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_count_ctrl.sv
// Two-digit BCD up/down counter with IDLE/RUN/PAUSE sequencing and registered
// active-low seven-segment outputs. Define SSEG_LEAD_ZERO_BLANK_EN to blank a zero tens digit.
module sseg_count_ctrl #(
    parameter int CLKS_PER_TICK = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_Stop,
    input  logic       i_Clear,
    input  logic       i_Up,
    output logic [6:0] o_Seg_Tens,
    output logic [6:0] o_Seg_Ones,
    output logic       o_Running,
    output logic       o_Wrap
);
    localparam int PW = $clog2(CLKS_PER_TICK);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);
`ifdef SSEG_LEAD_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif
    localparam logic [6:0] SEG_ZERO = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

    state_t        state_reg;
    logic          running_reg;
    logic [PW-1:0] presc_reg;
    logic [3:0]    digit_reg [2];   // [0] = ones, [1] = tens
    logic          wrap_evt_reg;
    logic          wrap_reg;
    logic          tick;
    logic          roll;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_encode = 7'b0000001;
            4'd1:    seg_encode = 7'b1001111;
            4'd2:    seg_encode = 7'b0010010;
            4'd3:    seg_encode = 7'b0000110;
            4'd4:    seg_encode = 7'b1001100;
            4'd5:    seg_encode = 7'b0100100;
            4'd6:    seg_encode = 7'b0100000;
            4'd7:    seg_encode = 7'b0001111;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0000100;
            default: seg_encode = 7'b1111111;
        endcase
    endfunction

    assign tick = (state_reg == ST_RUN) && (presc_reg == PRESC_LAST);
    assign roll = i_Up ? ((digit_reg[1] == 4'd9) && (digit_reg[0] == 4'd9))
                       : ((digit_reg[1] == 4'd0) && (digit_reg[0] == 4'd0));

    // Stop is decoded ahead of start so a coincident pair pauses RUN and is a no-op elsewhere.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_reg   <= ST_IDLE;
            running_reg <= 1'b0;
            presc_reg   <= '0;
        end else if (i_Clear) begin
            state_reg   <= ST_IDLE;
            running_reg <= 1'b0;
            presc_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    presc_reg <= '0;
                    if (i_Start && !i_Stop) begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    presc_reg <= tick ? '0 : presc_reg + 1'b1;
                    if (i_Stop) begin
                        state_reg   <= ST_PAUSE;
                        running_reg <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (i_Start && !i_Stop) begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    running_reg <= 1'b0;
                    presc_reg   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            digit_reg[0] <= 4'd0;
            digit_reg[1] <= 4'd0;
            wrap_evt_reg <= 1'b0;
        end else if (i_Clear) begin
            digit_reg[0] <= 4'd0;
            digit_reg[1] <= 4'd0;
            wrap_evt_reg <= 1'b0;
        end else begin
            wrap_evt_reg <= tick && roll;
            if (tick) begin
                if (i_Up) begin
                    if (digit_reg[0] == 4'd9) begin
                        digit_reg[0] <= 4'd0;
                        digit_reg[1] <= (digit_reg[1] == 4'd9) ? 4'd0 : digit_reg[1] + 4'd1;
                    end else begin
                        digit_reg[0] <= digit_reg[0] + 4'd1;
                    end
                end else begin
                    if (digit_reg[0] == 4'd0) begin
                        digit_reg[0] <= 4'd9;
                        digit_reg[1] <= (digit_reg[1] == 4'd0) ? 4'd9 : digit_reg[1] - 4'd1;
                    end else begin
                        digit_reg[0] <= digit_reg[0] - 4'd1;
                    end
                end
            end
        end
    end

    // Encode stage: one register per digit, so segments trail the count by one cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_digit
        localparam bit         BLANK_ZERO = LZ_BLANK && (gi == 1);
        localparam logic [6:0] SEG_RST    = BLANK_ZERO ? SEG_OFF : SEG_ZERO;
        logic [6:0] seg_reg;

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                seg_reg <= SEG_RST;
            end else if (BLANK_ZERO && (digit_reg[gi] == 4'd0)) begin
                seg_reg <= SEG_OFF;
            end else begin
                seg_reg <= seg_encode(digit_reg[gi]);
            end
        end
    end

    // Wrap is delayed to line up with the segment update it belongs to.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= wrap_evt_reg;
        end
    end

    assign o_Seg_Ones = gen_digit[0].seg_reg;
    assign o_Seg_Tens = gen_digit[1].seg_reg;
    assign o_Running  = running_reg;
    assign o_Wrap     = wrap_reg;
endmodule

// File: tb/tb_sseg_count_ctrl.sv
// Scoreboard bench for sseg_count_ctrl with CLKS_PER_TICK=4: expected display
// changes are queued with their due cycle and matched when the segments move.
module tb_sseg_count_ctrl;
    localparam int N = 4;

    typedef struct {
        int         cyc;
        logic [6:0] tens;
        logic [6:0] ones;
        logic       wrap;
    } exp_t;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L, i_Start, i_Stop, i_Clear, i_Up;
    logic [6:0] o_Seg_Tens, o_Seg_Ones;
    logic       o_Running, o_Wrap;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    exp_t       sb[$];
    bit         mon_en = 1'b0;
    logic [13:0] prev_segs;
    logic [6:0] seg_tab [10];

    int cnt = 0;
    int next_tick = 0;
    bit up_v = 1'b1;

    sseg_count_ctrl #(.CLKS_PER_TICK(N)) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Start    (i_Start),
        .i_Stop     (i_Stop),
        .i_Clear    (i_Clear),
        .i_Up       (i_Up),
        .o_Seg_Tens (o_Seg_Tens),
        .o_Seg_Ones (o_Seg_Ones),
        .o_Running  (o_Running),
        .o_Wrap     (o_Wrap)
    );

    always #5 i_Clk = ~i_Clk;
    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] exp_tens(input int v);
`ifdef SSEG_LEAD_ZERO_BLANK_EN
        if (v / 10 == 0) return 7'b1111111;
`endif
        return seg_tab[v / 10];
    endfunction

    function automatic logic [6:0] exp_ones(input int v);
        return seg_tab[v % 10];
    endfunction

    task automatic push(input int due, input int v, input logic w);
        exp_t e;
        e.cyc = due; e.tens = exp_tens(v); e.ones = exp_ones(v); e.wrap = w;
        sb.push_back(e);
    endtask

    // Model the count arithmetically (mod 100) and queue n upcoming ticks.
    task automatic sched_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            logic w;
            if (up_v) begin
                w = (cnt == 99);
                cnt = (cnt + 1) % 100;
            end else begin
                w = (cnt == 0);
                cnt = (cnt + 99) % 100;
            end
            push(next_tick + 1, cnt, w);
            next_tick += N;
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge i_Clk);
    endtask

    // Drives a one-cycle pulse from the current falling edge; p = sampling edge.
    task automatic pulse(input bit s, input bit t, input bit c, output int p);
        i_Start = s; i_Stop = t; i_Clear = c;
        p = cyc + 1;
        @(negedge i_Clk);
        i_Start = 1'b0; i_Stop = 1'b0; i_Clear = 1'b0;
    endtask

    always @(negedge i_Clk) begin
        if (mon_en) begin
            if ({o_Seg_Tens, o_Seg_Ones} !== prev_segs) begin
                if (sb.size() == 0) begin
                    chk("unexpected_change", int'({o_Seg_Tens, o_Seg_Ones}), int'(prev_segs));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("change_cycle", cyc, e.cyc);
                    chk("seg_tens", int'(o_Seg_Tens), int'(e.tens));
                    chk("seg_ones", int'(o_Seg_Ones), int'(e.ones));
                    chk("wrap", int'(o_Wrap), int'(e.wrap));
                end
                prev_segs = {o_Seg_Tens, o_Seg_Ones};
            end else if (o_Wrap !== 1'b0) begin
                chk("wrap_stray", int'(o_Wrap), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, s, k;
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        i_Rst_L = 1'b0; i_Start = 1'b0; i_Stop = 1'b0; i_Clear = 1'b0; i_Up = 1'b1;
        repeat (3) @(negedge i_Clk);
        chk("rst_tens", int'(o_Seg_Tens), int'(exp_tens(0)));
        chk("rst_ones", int'(o_Seg_Ones), 7'b0000001);
        chk("rst_running", int'(o_Running), 0);
        chk("rst_wrap", int'(o_Wrap), 0);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
        prev_segs = {o_Seg_Tens, o_Seg_Ones};
        mon_en = 1'b1;

        // Count up through 99 and wrap to 00.
        up_v = 1'b1; i_Up = 1'b1;
        pulse(1, 0, 0, p);
        chk("running_after_start", int'(o_Running), 1);
        next_tick = p + N;
        sched_ticks(100);
        wait_cyc(next_tick - N + 1);
        chk("running_mid", int'(o_Running), 1);

        // Down from 00 wraps to 99, then two more steps down.
        up_v = 1'b0; i_Up = 1'b0;
        sched_ticks(3);
        wait_cyc(next_tick - N + 1);

        // Pause two cycles into an interval, hold 20 cycles, resume.
        s = next_tick - 2;
        wait_cyc(s - 1);
        pulse(0, 1, 0, p);
        chk("running_paused", int'(o_Running), 0);
        wait_cyc(cyc + 20);
        k = p - (next_tick - N);
        pulse(1, 0, 0, p);
        chk("running_resumed", int'(o_Running), 1);
        next_tick = p + N - k;
        sched_ticks(1);
        wait_cyc(next_tick - N + 1);

        // Clear, count to 37, then clear coincident with the next tick.
        up_v = 1'b1; i_Up = 1'b1;
        pulse(0, 0, 1, p);
        cnt = 0;
        push(p + 1, 0, 1'b0);
        chk("running_cleared", int'(o_Running), 0);
        wait_cyc(p + 1);
        pulse(1, 0, 0, p);
        next_tick = p + N;
        sched_ticks(37);
        wait_cyc(next_tick - N + 1);
        wait_cyc(next_tick - 1);
        pulse(0, 0, 1, p);
        cnt = 0;
        push(p + 1, 0, 1'b0);
        chk("running_clear_on_tick", int'(o_Running), 0);
        wait_cyc(cyc + 10);
        pulse(1, 1, 0, p);
        chk("running_start_stop_idle", int'(o_Running), 0);
        wait_cyc(cyc + 10);
        chk("still_idle", int'(o_Running), 0);

        // Count to 58 and reset asynchronously mid-interval.
        pulse(1, 0, 0, p);
        next_tick = p + N;
        sched_ticks(58);
        wait_cyc(next_tick - N + 1);
        wait_cyc(cyc + 1);
        k = cyc;
        #2 i_Rst_L = 1'b0;
        cnt = 0;
        push(k + 1, 0, 1'b0);
        #1;
        chk("async_rst_tens", int'(o_Seg_Tens), int'(exp_tens(0)));
        chk("async_rst_ones", int'(o_Seg_Ones), 7'b0000001);
        chk("async_rst_running", int'(o_Running), 0);
        chk("async_rst_wrap", int'(o_Wrap), 0);
        repeat (3) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (6) @(negedge i_Clk);
        chk("post_rst_running", int'(o_Running), 0);
        chk("scoreboard_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
